// File: rtl/punch_detector_if.sv
// punch_detector_if: groups the per-frame glove position bus and the punch
// result bus of punch_detector.
//
// Signals
//   frame_valid          one-cycle strobe, glob_* valid this cycle
//   glob_glove{1,2}{x,y} global glove coordinates in mm, unsigned
//   punch{1,2}           one-cycle punch pulse per glove
//   dir{1,2}             punch direction, 1 = +x, 0 = -x
//   speed{1,2}           peak |dx| (mm/frame) of the last punch, held
//
// Modports
//   master : frame source / game logic side (drives frame_valid, glob_*)
//   slave  : punch_detector side (drives punch*, dir*, speed*)
interface punch_detector_if #(
    parameter int DATA_W = 16
);
    logic              frame_valid;
    logic [DATA_W-1:0] glob_glove1x;
    logic [DATA_W-1:0] glob_glove1y;
    logic [DATA_W-1:0] glob_glove2x;
    logic [DATA_W-1:0] glob_glove2y;
    logic              punch1;
    logic              punch2;
    logic              dir1;
    logic              dir2;
    logic [DATA_W-1:0] speed1;
    logic [DATA_W-1:0] speed2;

    modport master (
        output frame_valid, glob_glove1x, glob_glove1y, glob_glove2x, glob_glove2y,
        input  punch1, punch2, dir1, dir2, speed1, speed2
    );

    modport slave (
        input  frame_valid, glob_glove1x, glob_glove1y, glob_glove2x, glob_glove2y,
        output punch1, punch2, dir1, dir2, speed1, speed2
    );
endinterface

// File: rtl/punch_detector.sv
// punch_detector: per-glove punch detection from per-frame global glove
// positions. Each glove is tracked independently; a punch is declared when
// the forward horizontal speed |dx| stays at or above SPEED_THRESH with a
// constant sign for MIN_FRAMES consecutive frames. After a punch the glove
// ignores motion for COOLDOWN_FRAMES frames before re-arming.
//
// Ports
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    punch_detector_if.slave: frame_valid, glob_glove{1,2}{x,y} in;
//          punch{1,2}, dir{1,2}, speed{1,2} out (all outputs registered)
//
// Optional feature (compile-time macro PUNCH_HEIGHT_CHECK_EN):
//   defined   -> a frame only qualifies when Y_MIN <= y <= Y_MAX
//   undefined -> y inputs and Y_MIN/Y_MAX are ignored
module punch_detector #(
    parameter int DATA_W          = 16,
    parameter int SPEED_THRESH    = 40,
    parameter int MIN_FRAMES      = 3,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int Y_MIN           = 800,
    parameter int Y_MAX           = 2000
) (
    input logic             clk,
    input logic             reset,
    punch_detector_if.slave bus
);

    localparam int RUN_W  = $clog2(MIN_FRAMES + 1);
    localparam int COOL_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(MIN_FRAMES);
    localparam logic [RUN_W-1:0]  RUN_ONE    = RUN_W'(1);
    localparam logic [COOL_W-1:0] COOL_INIT  = COOL_W'(COOLDOWN_FRAMES);
    localparam logic [COOL_W-1:0] COOL_ONE   = COOL_W'(1);
    localparam logic [DATA_W-1:0] THRESH     = DATA_W'(SPEED_THRESH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    // |d| of a (DATA_W+1)-bit signed difference, clamped to DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W:0] d);
        logic [DATA_W:0] mag;
        mag = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
        return mag[DATA_W] ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] x_in [2];
    assign x_in[0] = bus.glob_glove1x;
    assign x_in[1] = bus.glob_glove2x;

`ifdef PUNCH_HEIGHT_CHECK_EN
    localparam logic [DATA_W-1:0] YMIN = DATA_W'(Y_MIN);
    localparam logic [DATA_W-1:0] YMAX = DATA_W'(Y_MAX);

    logic [DATA_W-1:0] y_in [2];
    assign y_in[0] = bus.glob_glove1y;
    assign y_in[1] = bus.glob_glove2y;
`else
    localparam bit unused_ybounds = (Y_MIN <= Y_MAX);
    logic [2*DATA_W-1:0] unused_y;
    assign unused_y = {bus.glob_glove1y, bus.glob_glove2y};
`endif

    // The very first frame after reset only loads the previous-x registers,
    // so no bogus dx against the reset value of 0 is ever evaluated.
    logic primed;

    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= 1'b0;
        end else if (bus.frame_valid) begin
            primed <= 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_glove
        state_t             state, state_nxt;
        logic [DATA_W-1:0]  x_prev;
        logic [RUN_W-1:0]   run, run_nxt;
        logic [DATA_W-1:0]  peak, peak_nxt;
        logic               dir_run, dir_run_nxt;
        logic [COOL_W-1:0]  cool, cool_nxt;
        logic               fire;

        logic signed [DATA_W:0] dx_p0;
        logic [DATA_W-1:0]      mag_p0;
        logic                   pos_p0;
        logic                   height_ok_p0;
        logic                   strong_p0;

        logic               punch_p1;
        logic               dir_p1;
        logic [DATA_W-1:0]  speed_p1;

        // ---- stage p0: frame delta and qualification (combinational) ----
        assign dx_p0  = $signed({1'b0, x_in[g]}) - $signed({1'b0, x_prev});
        assign mag_p0 = abs_sat(dx_p0);
        assign pos_p0 = ~dx_p0[DATA_W];

`ifdef PUNCH_HEIGHT_CHECK_EN
        assign height_ok_p0 = (y_in[g] >= YMIN) && (y_in[g] <= YMAX);
`else
        assign height_ok_p0 = 1'b1;
`endif

        // Meets speed (and height) on this frame; the sign match against
        // the running direction is checked inside the FSM.
        assign strong_p0 = primed && height_ok_p0 && (mag_p0 >= THRESH);

        always_comb begin
            state_nxt   = state;
            run_nxt     = run;
            peak_nxt    = peak;
            dir_run_nxt = dir_run;
            cool_nxt    = cool;
            fire        = 1'b0;

            if (bus.frame_valid) begin
                case (state)
                    IDLE: begin
                        if (strong_p0) begin
                            dir_run_nxt = pos_p0;
                            run_nxt     = RUN_ONE;
                            peak_nxt    = mag_p0;
                            state_nxt   = RUN;
                        end
                    end
                    RUN: begin
                        if (strong_p0 && (pos_p0 == dir_run)) begin
                            run_nxt  = (run >= RUN_TARGET) ? RUN_TARGET : run + RUN_ONE;
                            peak_nxt = (mag_p0 > peak) ? mag_p0 : peak;
                        end else if (strong_p0) begin
                            // Fast reversal: drop the old run and start a
                            // new one in the opposite direction right away.
                            dir_run_nxt = pos_p0;
                            run_nxt     = RUN_ONE;
                            peak_nxt    = mag_p0;
                        end else begin
                            run_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end
                    COOLDOWN: begin
                        if (cool <= COOL_ONE) begin
                            cool_nxt  = '0;
                            state_nxt = IDLE;
                        end else begin
                            cool_nxt = cool - COOL_ONE;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase

                // Completion is checked on the updated run count so a run
                // started from IDLE also fires when MIN_FRAMES is 1.
                if ((state_nxt == RUN) && (run_nxt >= RUN_TARGET)) begin
                    fire      = 1'b1;
                    run_nxt   = '0;
                    cool_nxt  = COOL_INIT;
                    state_nxt = COOLDOWN;
                end
            end
        end

        // ---- stage p1: registered state and outputs ----
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                x_prev   <= '0;
                run      <= '0;
                peak     <= '0;
                dir_run  <= 1'b0;
                cool     <= '0;
                punch_p1 <= 1'b0;
                dir_p1   <= 1'b0;
                speed_p1 <= '0;
            end else begin
                state    <= state_nxt;
                run      <= run_nxt;
                peak     <= peak_nxt;
                dir_run  <= dir_run_nxt;
                cool     <= cool_nxt;
                punch_p1 <= fire;
                if (bus.frame_valid) begin
                    x_prev <= x_in[g];
                end
                if (fire) begin
                    dir_p1   <= dir_run_nxt;
                    speed_p1 <= peak_nxt;
                end
            end
        end
    end

    assign bus.punch1 = g_glove[0].punch_p1;
    assign bus.punch2 = g_glove[1].punch_p1;
    assign bus.dir1   = g_glove[0].dir_p1;
    assign bus.dir2   = g_glove[1].dir_p1;
    assign bus.speed1 = g_glove[0].speed_p1;
    assign bus.speed2 = g_glove[1].speed_p1;

endmodule

// File: tb/tb_punch_detector.sv
// tb_punch_detector: directed bench for punch_detector. Each frame pushes
// the expected outputs for the following cycle (and for the idle gap cycle
// after it) into a scoreboard queue; entries are popped and compared when
// the registered outputs are sampled on the falling edge.
module tb_punch_detector;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    punch_detector_if #(.DATA_W(16)) bus ();

    punch_detector #(
        .DATA_W(16),
        .SPEED_THRESH(40),
        .MIN_FRAMES(3),
        .COOLDOWN_FRAMES(8),
        .Y_MIN(800),
        .Y_MAX(2000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic        p1;
        logic        p2;
        logic        d1;
        logic        d2;
        logic [15:0] s1;
        logic [15:0] s2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        hd1, hd2;
    logic [15:0] hs1, hs2;
    int          cx1, cx2;
    logic [15:0] cy;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) n_pass++;
        else begin
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, " punch1"}, 16'(bus.punch1), 16'(e.p1));
        chk({tag, " punch2"}, 16'(bus.punch2), 16'(e.p2));
        chk({tag, " dir1"},   16'(bus.dir1),   16'(e.d1));
        chk({tag, " dir2"},   16'(bus.dir2),   16'(e.d2));
        chk({tag, " speed1"}, bus.speed1, e.s1);
        chk({tag, " speed2"}, bus.speed2, e.s2);
    endtask

    // One frame with glove deltas d1/d2, then one idle cycle; p1/p2 say
    // whether each glove must pulse on the cycle after this frame.
    task automatic step(input int d1, input int d2, input logic p1, input logic p2,
                        input string tag);
        cx1 += d1;
        cx2 += d2;
        @(negedge clk);
        bus.frame_valid  = 1'b1;
        bus.glob_glove1x = 16'(cx1);
        bus.glob_glove2x = 16'(cx2);
        bus.glob_glove1y = cy;
        bus.glob_glove2y = cy;
        sb.push_back('{p1, p2, hd1, hd2, hs1, hs2});
        @(negedge clk);
        bus.frame_valid = 1'b0;
        compare_out(tag);
        sb.push_back('{1'b0, 1'b0, hd1, hd2, hs1, hs2});
        @(negedge clk);
        compare_out({tag, " gap"});
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, "settle");
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        bus.frame_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        hd1 = 1'b0; hd2 = 1'b0; hs1 = 16'd0; hs2 = 16'd0;
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0});
        compare_out(tag);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        bus.frame_valid  = 1'b0;
        bus.glob_glove1x = '0;
        bus.glob_glove1y = '0;
        bus.glob_glove2x = '0;
        bus.glob_glove2y = '0;
        cy  = 16'd1200;
        cx1 = 0;
        cx2 = 0;

        do_reset("reset");

        // Glove 1 forward punch at 50 mm/frame
        cx1 = 1000; cx2 = 3000;
        step(0,  0, 1'b0, 1'b0, "t1 prime");
        step(50, 0, 1'b0, 1'b0, "t1 f2");
        step(50, 0, 1'b0, 1'b0, "t1 f3");
        hd1 = 1'b1; hs1 = 16'd50;
        step(50, 0, 1'b1, 1'b0, "t1 punch");
        step(50, 0, 1'b0, 1'b0, "t1 cool");

        // Glove 2 backward punch, peak 100
        step(0, 0,    1'b0, 1'b0, "t2 f1");
        step(0, -100, 1'b0, 1'b0, "t2 f2");
        step(0, -50,  1'b0, 1'b0, "t2 f3");
        hd2 = 1'b0; hs2 = 16'd100;
        step(0, -70,  1'b0, 1'b1, "t2 punch");
        settle(8);

        // Slow frame breaks the run
        step(50, 0, 1'b0, 1'b0, "t3 a");
        step(50, 0, 1'b0, 1'b0, "t3 b");
        step(10, 0, 1'b0, 1'b0, "t3 slow");
        step(50, 0, 1'b0, 1'b0, "t3 c");
        step(50, 0, 1'b0, 1'b0, "t3 d");

        // Third fast frame completes the run, then cooldown, then re-arm
        hd1 = 1'b1; hs1 = 16'd60;
        step(60, 0, 1'b1, 1'b0, "t4 punch");
        for (int i = 0; i < 8; i++) step(60, 0, 1'b0, 1'b0, "t4 cool");
        step(60, 0, 1'b0, 1'b0, "t4 rearm1");
        step(60, 0, 1'b0, 1'b0, "t4 rearm2");
        step(60, 0, 1'b1, 1'b0, "t4 punch2");

        // Glove 2 sign reversal restarts the run immediately
        step(0, -50, 1'b0, 1'b0, "t5 n1");
        step(0, -50, 1'b0, 1'b0, "t5 n2");
        step(0, 50,  1'b0, 1'b0, "t5 rev");
        step(0, 50,  1'b0, 1'b0, "t5 p2");
        hd2 = 1'b1; hs2 = 16'd50;
        step(0, 50,  1'b0, 1'b1, "t5 punch");
        settle(8);

        // Both gloves punch on the same cycle
        step(45, -45, 1'b0, 1'b0, "t6 a");
        step(45, -45, 1'b0, 1'b0, "t6 b");
        hd1 = 1'b1; hs1 = 16'd45; hd2 = 1'b0; hs2 = 16'd45;
        step(45, -45, 1'b1, 1'b1, "t6 both");
        settle(8);

        // Reset in the middle of a run: no pulse, next frame only primes
        step(60, 0, 1'b0, 1'b0, "t7 r1");
        step(60, 0, 1'b0, 1'b0, "t7 r2");
        do_reset("t7 reset");
        step(60, 0, 1'b0, 1'b0, "t7 prime");
        step(60, 0, 1'b0, 1'b0, "t7 a");
        step(60, 0, 1'b0, 1'b0, "t7 b");
        hd1 = 1'b1; hs1 = 16'd60;
        step(60, 0, 1'b1, 1'b0, "t7 punch");

`ifdef PUNCH_HEIGHT_CHECK_EN
        settle(8);
        cy = 16'd500;
        step(60, 0, 1'b0, 1'b0, "t8 low a");
        step(60, 0, 1'b0, 1'b0, "t8 low b");
        step(60, 0, 1'b0, 1'b0, "t8 low c");
        cy = 16'd1200;
        step(60, 0, 1'b0, 1'b0, "t8 ok a");
        step(60, 0, 1'b0, 1'b0, "t8 ok b");
        hd1 = 1'b1; hs1 = 16'd60;
        step(60, 0, 1'b1, 1'b0, "t8 punch");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/punch_detector.md
Name: punch_detector

Overview:
- Downstream consumer of the global glove coordinate stage; samples per-frame global glove positions in millimetres.
- Tracks each glove independently and flags a punch when forward horizontal speed stays above threshold for consecutive frames.
- Feeds game logic (hit/score FSM) with single-cycle punch pulses plus peak speed and direction.

Parameters:
- SPEED_THRESH, 40, minimum |dx| per frame in mm to count as punching motion
- MIN_FRAMES, 3, consecutive qualifying frames required to declare a punch
- COOLDOWN_FRAMES, 8, frames ignored after a punch before re-arming
- Y_MIN, 800, lower glove height bound in mm (optional feature only)
- Y_MAX, 2000, upper glove height bound in mm (optional feature only)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_valid  input  1  one-cycle strobe; glob_* inputs valid this cycle, once per video frame
- glob_glove1x  input  16  glove 1 global x, mm, unsigned
- glob_glove1y  input  16  glove 1 global y, mm, unsigned
- glob_glove2x  input  16  glove 2 global x, mm, unsigned
- glob_glove2y  input  16  glove 2 global y, mm, unsigned
- punch1  output  1  one-cycle pulse, glove 1 punch detected
- punch2  output  1  one-cycle pulse, glove 2 punch detected
- dir1  output  1  glove 1 punch direction: 1 = +x, 0 = -x
- dir2  output  1  glove 2 punch direction
- speed1  output  16  glove 1 peak |dx| (mm/frame) during the punch, held until the next punch
- speed2  output  16  glove 2 peak |dx|, held

Behaviour:
- Clocking: one clock `clk`; `reset` is synchronous and active-high. All outputs registered. Reset values: punch1/2 = 0, dir1/2 = 0, speed1/2 = 0, all FSMs in IDLE, prev registers 0, primed = 0.
- Per glove, on each frame_valid: dx = {1'b0,x} - {1'b0,x_prev}, 17-bit signed; |dx| saturates to 16 bits; x_prev <= x.
- primed flag: first frame_valid after reset only loads x_prev and sets primed; no dx is evaluated on that frame.
- Qualifying frame: primed, |dx| >= SPEED_THRESH, and sign(dx) equals the sign latched at run start (the first frame of a run latches it).
- FSM states:
  - IDLE: a qualifying frame latches dir, sets run = 1, sets peak = |dx|, and moves to RUN.
  - RUN: a qualifying frame with the same sign increments run and updates peak = max. When run reaches MIN_FRAMES, assert punch for exactly one cycle, load speed/dir, load cool = COOLDOWN_FRAMES, and go to COOLDOWN. A non-qualifying frame or a sign reversal returns to IDLE; a sign-reversal frame that meets the threshold immediately starts a new run (IDLE behaviour applied the same frame).
  - COOLDOWN: each frame_valid decrements cool; x_prev still updates. At cool = 0, return to IDLE. No detection during COOLDOWN.
- Latency: punch pulse asserts on the cycle after the frame_valid that completes MIN_FRAMES.
- No frame_valid: state holds and punch stays 0.
- Gloves are fully independent; both may pulse on the same cycle.
- Counters: run saturates at MIN_FRAMES; cool does not underflow.
- Reset mid-RUN or mid-COOLDOWN: immediate return to reset values; no pulse is emitted.

Optional Feature:
- Macro: PUNCH_HEIGHT_CHECK_EN.
- Defined: a frame qualifies only if Y_MIN <= y <= Y_MAX, inclusive. An out-of-range frame in RUN aborts to IDLE.
- Undefined: y inputs are ignored, and Y_MIN/Y_MAX are unused.

Test Plan:
- Reset, then glove1 x = 1000, 1050, 1100, 1150, 1200 on successive frames (defaults) -> frame 1 primes only; punch1 pulses one cycle after the 4th frame; dir1 = 1; speed1 = 50.
- Glove2 x = 3000, 2900, 2850, 2780 -> punch2 pulses after the 4th frame; dir2 = 0; speed2 = 100 (peak); punch1 stays 0.
- Glove1 deltas +50, +50, +10, +50, +50 -> no punch; the run resets on the +10 frame.
- After a punch, continue +60/frame for 8 frames -> no second pulse during cooldown. The 9th frame opens a new run, and a punch follows after 3 more qualifying frames.
- Assert reset during RUN (run = 2), then deassert -> no pulse, outputs 0. The next frame only primes.
- With PUNCH_HEIGHT_CHECK_EN, y = 500 and x deltas +60 ×3 -> no punch. Repeat with y = 1200 -> punch1 pulses.
